// File: rtl/mult_share_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_arb_pkg
// Description : Shared widths, ID width helper and pipeline-stage entry type
//               for the shared-multiplier arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_arb_pkg;

  localparam int unsigned C_A_W      = 16;
  localparam int unsigned C_B_W      = 13;
  localparam int unsigned C_P_W      = C_A_W + C_B_W;
  // Widest requester ID a stage entry can carry (up to 256 requesters).
  localparam int unsigned C_ID_MAX_W = 8;

  // Requester index width; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned nreq);
    return (nreq <= 2) ? 1 : $clog2(nreq);
  endfunction

  // One slot of the valid/ID tracking pipeline.
  typedef struct packed {
    logic                  valid;
    logic [C_ID_MAX_W-1:0] id;
  } stage_t;

endpackage
`default_nettype wire

// File: rtl/mult_share_arbiter_mul.sv
`default_nettype none
// ============================================================================
// Module      : mult_ce_pipe
// Description : Clock-enable gated pipelined unsigned multiplier with LAT
//               register stages. Datapath only; no reset.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_ce_pipe
  import mult_arb_pkg::*;
#(
  parameter int unsigned A_W = C_A_W,
  parameter int unsigned B_W = C_B_W,
  parameter int unsigned LAT = 1,
  localparam int unsigned P_W = A_W + B_W
) (
  input  logic           clk_i,
  input  logic           ce_i,
  input  logic [A_W-1:0] a_i,
  input  logic [B_W-1:0] b_i,
  output logic [P_W-1:0] p_o
);

  logic [P_W-1:0] prod_w;
  logic [P_W-1:0] stage_q [LAT];

  assign prod_w = {{B_W{1'b0}}, a_i} * {{A_W{1'b0}}, b_i};

  // Product pipeline; freezes entirely when ce is low.
  always_ff @(posedge clk_i) begin
    if (ce_i) begin
      stage_q[0] <= prod_w;
      for (int unsigned i = 1; i < LAT; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign p_o = stage_q[LAT-1];

endmodule
`default_nettype wire

// File: rtl/mult_share_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter. Combinational grant scanning from the
//               requester after the last accepted one; pointer register
//               updates only when a grant is actually issued.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import mult_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = id_width(NREQ)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            en_i,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [ID_W-1:0] idx_o
);

  localparam logic [ID_W-1:0] C_LAST = ID_W'(NREQ - 1);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;
  logic [ID_W-1:0] cand_w;
  logic [ID_W-1:0] idx_w;
  logic            found_w;

  // Walk the requesters starting just past the pointer, wrapping at NREQ.
  always_comb begin
    found_w = 1'b0;
    idx_w   = '0;
    cand_w  = ptr_q;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand_w = (cand_w == C_LAST) ? '0 : cand_w + ID_W'(1);
      if (!found_w && req_i[cand_w]) begin
        found_w = 1'b1;
        idx_w   = cand_w;
      end
    end
  end

  // Grant is only offered while the pipeline can advance and not in reset.
  always_comb begin
    gnt_o = '0;
    if (en_i && !reset_i && found_w) begin
      gnt_o = NREQ'(1) << idx_w;
    end
  end

  assign idx_o = idx_w;
  assign ptr_d = (en_i && found_w) ? idx_w : ptr_q;

  // Pointer remembers the last accepted requester; NREQ-1 favours 0 first.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q <= C_LAST;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mult_share_arbiter
// Description : Shares one pipelined multiplier among NREQ requesters.
//               Round-robin grant, one issue per cycle, requester ID carried
//               alongside each product, single valid/ready result port whose
//               backpressure freezes the whole pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned A_W     = C_A_W,
  parameter int unsigned B_W     = C_B_W,
  parameter int unsigned P_W     = C_P_W,
  parameter int unsigned MUL_LAT = 1,
  localparam int unsigned ID_W   = id_width(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*A_W-1:0] req_a,
  input  logic [NREQ*B_W-1:0] req_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ID_W-1:0]   res_id,
  output logic [P_W-1:0]    res_data,
  output logic              busy
);

  if (P_W != A_W + B_W) begin : g_chk_pw
    $error("P_W must equal A_W+B_W");
  end
  if (ID_W > C_ID_MAX_W) begin : g_chk_idw
    $error("NREQ too large for stage entry ID field");
  end

  stage_t            pipe_q [MUL_LAT];
  stage_t            pipe_d;
  logic              adv_w;
  logic              accept_w;
  logic [NREQ-1:0]   gnt_w;
  logic [ID_W-1:0]   gidx_w;
  logic [A_W-1:0]    a_sel_w;
  logic [B_W-1:0]    b_sel_w;
  logic [P_W-1:0]    prod_w;
  logic [MUL_LAT-1:0] vbits_w;

  // The pipeline moves whenever the output slot is empty or being consumed.
  assign res_valid = pipe_q[MUL_LAT-1].valid;
  assign adv_w     = !res_valid || res_ready;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .clk_i   (clk),
    .reset_i (reset),
    .en_i    (adv_w),
    .req_i   (req_valid),
    .gnt_o   (gnt_w),
    .idx_o   (gidx_w)
  );

  assign req_ready = gnt_w;
  assign accept_w  = |gnt_w;

  // Operands of the granted requester feed the multiplier directly.
  assign a_sel_w = req_a[32'(gidx_w) * A_W +: A_W];
  assign b_sel_w = req_b[32'(gidx_w) * B_W +: B_W];

  mult_ce_pipe #(
    .A_W (A_W),
    .B_W (B_W),
    .LAT (MUL_LAT)
  ) u_mul (
    .clk_i (clk),
    .ce_i  (adv_w),
    .a_i   (a_sel_w),
    .b_i   (b_sel_w),
    .p_o   (prod_w)
  );

  // Entry for stage 0: the accepted requester, or a bubble.
  always_comb begin
    pipe_d.valid = accept_w;
    pipe_d.id    = accept_w ? C_ID_MAX_W'(gidx_w) : '0;
  end

  // Valid/ID shift register, kept in lock-step with the multiplier stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < MUL_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else if (adv_w) begin
      pipe_q[0] <= pipe_d;
      for (int unsigned i = 1; i < MUL_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  for (genvar gi = 0; gi < MUL_LAT; gi++) begin : g_vbits
    assign vbits_w[gi] = pipe_q[gi].valid;
  end

  assign busy     = |vbits_w;
  assign res_id   = res_valid ? ID_W'(pipe_q[MUL_LAT-1].id) : '0;
  assign res_data = res_valid ? prod_w : '0;

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_share_arbiter
// Description : Self-checking bench for mult_share_arbiter: reference RR and
//               pipeline model with result scoreboard, vector table, directed
//               corner sequences and a random soak.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_share_arbiter;

  localparam int NREQ    = 4;
  localparam int A_W     = 16;
  localparam int B_W     = 13;
  localparam int P_W     = 29;
  localparam int MUL_LAT = 1;
  localparam int ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*A_W-1:0]  req_a;
  logic [NREQ*B_W-1:0]  req_b;
  logic                 res_valid;
  logic                 res_ready;
  logic [ID_W-1:0]      res_id;
  logic [P_W-1:0]       res_data;
  logic                 busy;

  mult_share_arbiter #(
    .NREQ    (NREQ),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_data  (res_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             id;
    logic [P_W-1:0] p;
  } sb_t;

  typedef struct {
    int             id;
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic [P_W-1:0] p;
  } vec_t;

  sb_t              sb[$];
  int               n_checks = 0;
  int               n_errors = 0;
  int               m_ptr;
  logic [MUL_LAT-1:0] m_v;
  int               wait_cnt[NREQ];

  logic [NREQ-1:0]  s_req_ready;
  logic             s_res_valid;
  logic [ID_W-1:0]  s_res_id;
  logic [P_W-1:0]   s_res_data;
  logic             s_busy;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_op(input int i, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    req_a[i*A_W +: A_W] = a;
    req_b[i*B_W +: B_W] = b;
  endtask

  // One clock: sample mid-cycle, compare against the model, advance the model.
  task automatic cycle();
    int              g;
    logic            exp_rv;
    logic            adv;
    logic [NREQ-1:0] exp_rdy;
    logic [63:0]     pa, pb;
    #2;
    s_req_ready = req_ready;
    s_res_valid = res_valid;
    s_res_id    = res_id;
    s_res_data  = res_data;
    s_busy      = busy;
    if (reset) begin
      chk("req_ready_in_reset", req_ready, 0);
      m_v   = '0;
      m_ptr = NREQ - 1;
      sb.delete();
      for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    end else begin
      exp_rv = m_v[MUL_LAT-1];
      adv    = !exp_rv || res_ready;
      g      = -1;
      if (adv) begin
        for (int k = 1; k <= NREQ; k++) begin
          int c;
          c = (m_ptr + k) % NREQ;
          if (g < 0 && req_valid[c]) g = c;
        end
      end
      exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
      chk("req_ready", req_ready, exp_rdy);
      chk("res_valid", res_valid, exp_rv);
      chk("busy", busy, |m_v);
      if (exp_rv && sb.size() > 0) begin
        chk("res_id", res_id, sb[0].id);
        chk("res_data", res_data, sb[0].p);
        if (res_ready) void'(sb.pop_front());
      end else begin
        chk("res_data_masked", res_data, 0);
      end
      // Starvation: a continuously waiting requester sees at most NREQ-1 other grants.
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || req_ready[i]) begin
          wait_cnt[i] = 0;
        end else if (|req_ready) begin
          wait_cnt[i]++;
          n_checks++;
          if (wait_cnt[i] > NREQ - 1) begin
            n_errors++;
            $display("FAIL starve: req %0d waited %0d grants, limit %0d", i, wait_cnt[i], NREQ - 1);
          end
        end
      end
      if (adv) begin
        for (int k = MUL_LAT - 1; k > 0; k--) m_v[k] = m_v[k-1];
        m_v[0] = (g >= 0);
        if (g >= 0) begin
          pa = 64'(req_a[g*A_W +: A_W]);
          pb = 64'(req_b[g*B_W +: B_W]);
          sb.push_back('{g, P_W'(pa * pb)});
          m_ptr = g;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    res_ready = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic drain();
    req_valid = '0;
    res_ready = 1'b1;
    for (int i = 0; i < MUL_LAT + 4; i++) cycle();
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    vec_t tbl[7];
    int   exp_g[6];
    int   exp_d[6];
    logic [31:0] r;

    tbl[0] = '{0, 16'hFFFF, 13'h1FFF, 29'h1FFEE001};
    tbl[1] = '{2, 16'h0000, 13'h1ABC, 29'h0};
    tbl[2] = '{2, 16'h1234, 13'h0000, 29'h0};
    tbl[3] = '{1, 16'h0001, 13'h0001, 29'h1};
    tbl[4] = '{3, 16'h8000, 13'h1000, 29'h8000000};
    tbl[5] = '{1, 16'h00FF, 13'h0101, 29'hFFFF};
    tbl[6] = '{3, 16'hFFFF, 13'h0001, 29'hFFFF};
    exp_g  = '{0, 1, 2, 3, 0, 1};
    exp_d  = '{3, 6, 9, 12, 3, 6};

    reset     = 1'b1;
    req_valid = '0;
    res_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;

    // Reset state
    do_reset();
    cycle();
    chk("reset_res_valid", s_res_valid, 0);
    chk("reset_res_id", s_res_id, 0);
    chk("reset_res_data", s_res_data, 0);
    chk("reset_busy", s_busy, 0);
    chk("reset_req_ready", s_req_ready, 0);

    // Vector table: single requester, one-cycle latency result
    for (int i = 0; i < 7; i++) begin
      req_valid = NREQ'(1) << tbl[i].id;
      set_op(tbl[i].id, tbl[i].a, tbl[i].b);
      cycle();
      chk("tbl_req_ready", s_req_ready, NREQ'(1) << tbl[i].id);
      req_valid = '0;
      cycle();
      chk("tbl_res_valid", s_res_valid, 1);
      chk("tbl_res_id", s_res_id, tbl[i].id);
      chk("tbl_res_data", s_res_data, tbl[i].p);
    end
    drain();

    // All four continuously valid: round-robin order and back-to-back results
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, A_W'(i + 1), B_W'(3));
    req_valid = '1;
    for (int k = 0; k < 7; k++) begin
      if (k == 6) req_valid = '0;
      cycle();
      if (k < 6) chk("rr_grant", s_req_ready, NREQ'(1) << exp_g[k]);
      if (k >= 1) begin
        chk("rr_res_id", s_res_id, exp_g[k-1]);
        chk("rr_res_data", s_res_data, exp_d[k-1]);
      end
    end
    drain();

    // Stall: requesters 1 and 3, result port held off for three cycles
    do_reset();
    set_op(1, 16'h0005, 13'h0007);
    set_op(3, 16'h0100, 13'h0011);
    req_valid = 4'b1010;
    cycle();
    chk("stall_first_grant", s_req_ready, 4'b0010);
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_op(1, A_W'($urandom), B_W'($urandom));
      set_op(3, 16'h0100, 13'h0011);
      cycle();
      chk("stall_res_valid", s_res_valid, 1);
      chk("stall_res_id", s_res_id, 1);
      chk("stall_res_data", s_res_data, 35);
      chk("stall_req_ready", s_req_ready, 0);
    end
    res_ready = 1'b1;
    cycle();
    chk("stall_release_grant", s_req_ready, 4'b1000);
    req_valid = '0;
    cycle();
    chk("stall_next_id", s_res_id, 3);
    chk("stall_next_data", s_res_data, 29'h1100);
    drain();

    // Reset with a product in flight
    do_reset();
    req_valid = 4'b0100;
    set_op(2, 16'h0003, 13'h0003);
    cycle();
    req_valid = '0;
    reset     = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    chk("rst_flight_res_valid", s_res_valid, 0);
    chk("rst_flight_busy", s_busy, 0);
    req_valid = '1;
    cycle();
    chk("rst_flight_grant", s_req_ready, 4'b0001);
    drain();

    // Zero operands from requester 2; pointer then parked on 2
    do_reset();
    req_valid = 4'b0100;
    set_op(2, 16'h0000, 13'h1ABC);
    cycle();
    set_op(2, 16'h1234, 13'h0000);
    cycle();
    chk("zero_res_id0", s_res_id, 2);
    chk("zero_res_data0", s_res_data, 0);
    chk("zero_res_valid0", s_res_valid, 1);
    req_valid = '0;
    set_op(1, 16'h0002, 13'h0002);
    set_op(3, 16'h0004, 13'h0004);
    cycle();
    chk("zero_res_id1", s_res_id, 2);
    chk("zero_res_valid1", s_res_valid, 1);
    req_valid = 4'b1010;
    cycle();
    chk("ptr_after_two", s_req_ready, 4'b1000);
    drain();

    // Random soak
    do_reset();
    for (int k = 0; k < 10000; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        r = $urandom;
        if ($urandom_range(0, 7) == 0) set_op(i, 16'hFFFF, 13'h1FFF);
        else set_op(i, r[A_W-1:0], r[28:16]);
      end
      r         = $urandom;
      req_valid = r[NREQ-1:0];
      res_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
